// File: rtl/alu_pkg.sv
// Shared ALU operation codes, RV32I opcode and funct7 constants for the decode stage.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [5:0] ALU_ADD   = 6'd0;
    localparam logic [5:0] ALU_SUB   = 6'd1;
    localparam logic [5:0] ALU_SLL   = 6'd2;
    localparam logic [5:0] ALU_SLT   = 6'd3;
    localparam logic [5:0] ALU_SLTU  = 6'd4;
    localparam logic [5:0] ALU_XOR   = 6'd5;
    localparam logic [5:0] ALU_SRL   = 6'd6;
    localparam logic [5:0] ALU_SRA   = 6'd7;
    localparam logic [5:0] ALU_OR    = 6'd8;
    localparam logic [5:0] ALU_AND   = 6'd9;
    localparam logic [5:0] ALU_PASS2 = 6'd10;
    localparam logic [5:0] ALU_NOP   = 6'd63;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Base funct3 -> ALU code map shared by OP and OP-IMM (the funct7=0 flavour).
    function automatic logic [5:0] f3_alu_op(input logic [2:0] funct3);
        logic [5:0] op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Decode-to-execute bundle: instruction input handshake plus the registered ALU control slot.
// Latency: n/a (wiring only).
// Backpressure: OUT_READY low stalls the slot, which pulls IN_READY low unless FLUSH is set.
interface alu_decode_stage_if #(
    parameter int INPUT_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
);
    logic                   IN_VALID;
    logic                   IN_READY;
    logic [31:0]            INSTRUCTION;
    logic                   FLUSH;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic [5:0]             ALU_INSTRUCTION;
    logic [5:0]             SHIFT_AMOUNT;
    logic                   SHAMT_SRC;
    logic                   ALU_SRC1;
    logic                   ALU_SRC2;
    logic [INPUT_WIDTH-1:0] IMMEDIATE;
    logic                   ILLEGAL;
    logic [CNT_WIDTH-1:0]   ILLEGAL_COUNT;

    // The decode stage drives the ALU control side and IN_READY.
    modport master (
        input  IN_VALID, INSTRUCTION, FLUSH, OUT_READY,
        output IN_READY, OUT_VALID, ALU_INSTRUCTION, SHIFT_AMOUNT, SHAMT_SRC,
               ALU_SRC1, ALU_SRC2, IMMEDIATE, ILLEGAL, ILLEGAL_COUNT
    );

    // Fetch front end and execute stage seen as one environment.
    modport slave (
        output IN_VALID, INSTRUCTION, FLUSH, OUT_READY,
        input  IN_READY, OUT_VALID, ALU_INSTRUCTION, SHIFT_AMOUNT, SHAMT_SRC,
               ALU_SRC1, ALU_SRC2, IMMEDIATE, ILLEGAL, ILLEGAL_COUNT
    );
endinterface

// File: rtl/alu_decode_comb.sv
// Pure RV32I -> ALU control decode; unsupported encodings give NOP with all selects/immediate zero.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller decides when the result is captured.
module alu_decode_comb
    import alu_pkg::*;
#(
    parameter int INPUT_WIDTH = 32
) (
    input  logic [31:0]            instruction,
    output logic [5:0]             alu_op,
    output logic [5:0]             shift_amount,
    output logic                   shamt_src,
    output logic                   alu_src1,
    output logic                   alu_src2,
    output logic [INPUT_WIDTH-1:0] immediate,
    output logic                   illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm32;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // Classify by opcode, then collapse every illegal case to the canonical NOP encoding.
    always_comb begin
        alu_op       = ALU_NOP;
        shift_amount = {1'b0, instruction[24:20]};
        shamt_src    = 1'b0;
        alu_src1     = 1'b0;
        alu_src2     = 1'b0;
        imm32        = '0;
        illegal      = 1'b0;
        case (opcode)
            OPC_OP: begin
                shamt_src = (funct3 == 3'b001) || (funct3 == 3'b101);
                if (funct7 == F7_ZERO)                        alu_op = f3_alu_op(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000) alu_op = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101) alu_op = ALU_SRA;
                else                                           illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                alu_src2 = 1'b1;
                imm32    = imm_i;
                // Shift-immediates reuse funct7 as a qualifier; other funct3 carry pure immediate bits.
                if (funct3 == 3'b001 && funct7 != F7_ZERO)     illegal = 1'b1;
                else if (funct3 == 3'b101 && funct7 == F7_ALT) alu_op = ALU_SRA;
                else if (funct3 == 3'b101 && funct7 != F7_ZERO) illegal = 1'b1;
                else                                           alu_op = f3_alu_op(funct3);
            end
            OPC_LOAD: begin
                alu_op   = ALU_ADD;
                alu_src2 = 1'b1;
                imm32    = imm_i;
            end
            OPC_STORE: begin
                alu_op   = ALU_ADD;
                alu_src2 = 1'b1;
                imm32    = imm_s;
            end
            OPC_BRANCH: begin
                imm32 = imm_b;
                case (funct3)
                    3'b000, 3'b001: alu_op = ALU_SUB;
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                alu_op   = ALU_PASS2;
                alu_src2 = 1'b1;
                imm32    = imm_u;
            end
            OPC_AUIPC: begin
                alu_op   = ALU_ADD;
                alu_src1 = 1'b1;
                alu_src2 = 1'b1;
                imm32    = imm_u;
            end
            OPC_JAL: begin
                alu_op   = ALU_ADD;
                alu_src1 = 1'b1;
                alu_src2 = 1'b1;
                imm32    = imm_j;
            end
            OPC_JALR: begin
                alu_op   = ALU_ADD;
                alu_src2 = 1'b1;
                imm32    = imm_i;
                if (funct3 != 3'b000) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            alu_op       = ALU_NOP;
            shift_amount = '0;
            shamt_src    = 1'b0;
            alu_src1     = 1'b0;
            alu_src2     = 1'b0;
            imm32        = '0;
        end
    end

    assign immediate = INPUT_WIDTH'($signed(imm32));

endmodule

// File: rtl/alu_decode_stage.sv
// Single-slot registered decode stage feeding the ALU control interface, with illegal-op counter.
// Latency: 1 cycle from acceptance to OUT_VALID; full throughput when OUT_READY stays high.
// Backpressure: IN_READY = ~OUT_VALID | OUT_READY | FLUSH; a stalled slot holds every output.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic         CLK,
    input  logic         RST,
    alu_decode_stage_if.master bus
);

    logic [5:0]             dec_op;
    logic [5:0]             dec_shamt;
    logic                   dec_shamt_src;
    logic                   dec_src1;
    logic                   dec_src2;
    logic [INPUT_WIDTH-1:0] dec_imm;
    logic                   dec_illegal;

    logic                   out_valid;
    logic [5:0]             alu_op_q;
    logic [5:0]             shamt_q;
    logic                   shamt_src_q;
    logic                   src1_q;
    logic                   src2_q;
    logic [INPUT_WIDTH-1:0] imm_q;
    logic                   illegal_q;
    logic [CNT_WIDTH-1:0]   illegal_cnt;
    logic                   in_ready;
    logic                   load;

    alu_decode_comb #(.INPUT_WIDTH(INPUT_WIDTH)) u_decode (
        .instruction  (bus.INSTRUCTION),
        .alu_op       (dec_op),
        .shift_amount (dec_shamt),
        .shamt_src    (dec_shamt_src),
        .alu_src1     (dec_src1),
        .alu_src2     (dec_src2),
        .immediate    (dec_imm),
        .illegal      (dec_illegal)
    );

    assign in_ready = ~out_valid | bus.OUT_READY | bus.FLUSH;
    assign load     = bus.IN_VALID & in_ready & ~bus.FLUSH;

    // Pipeline slot: flush beats load beats consume; data regs only move on load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid   <= 1'b0;
            alu_op_q    <= ALU_NOP;
            shamt_q     <= '0;
            shamt_src_q <= 1'b0;
            src1_q      <= 1'b0;
            src2_q      <= 1'b0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
            illegal_cnt <= '0;
        end else if (bus.FLUSH) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            alu_op_q    <= dec_op;
            shamt_q     <= dec_shamt;
            shamt_src_q <= dec_shamt_src;
            src1_q      <= dec_src1;
            src2_q      <= dec_src2;
            imm_q       <= dec_imm;
            illegal_q   <= dec_illegal;
            if (dec_illegal && illegal_cnt != '1) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end
        end else if (out_valid && bus.OUT_READY) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.IN_READY        = in_ready;
    assign bus.OUT_VALID       = out_valid;
    assign bus.ALU_INSTRUCTION = alu_op_q;
    assign bus.SHIFT_AMOUNT    = shamt_q;
    assign bus.SHAMT_SRC       = shamt_src_q;
    assign bus.ALU_SRC1        = src1_q;
    assign bus.ALU_SRC2        = src2_q;
    assign bus.IMMEDIATE       = imm_q;
    assign bus.ILLEGAL         = illegal_q;
    assign bus.ILLEGAL_COUNT   = illegal_cnt;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed plus randomized bench for alu_decode_stage against a table-driven reference decoder.
// Latency: expects decoded outputs one edge after acceptance.
// Backpressure: drives OUT_READY/FLUSH patterns and checks IN_READY before every edge.
module tb_alu_decode_stage;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    alu_decode_stage_if #(.INPUT_WIDTH(32), .CNT_WIDTH(16)) bus ();

    alu_decode_stage #(.INPUT_WIDTH(32), .CNT_WIDTH(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  shamt;
        logic        shsrc;
        logic        s1;
        logic        s2;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    localparam logic [5:0] F3_CODE [8] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9};
    localparam logic [6:0] OPC_LIST [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                             7'h37, 7'h17, 7'h6F, 7'h67, 7'h0B};

    int checks = 0;
    int errors = 0;

    dec_t        m_dec;
    logic        m_valid;
    logic [15:0] m_cnt;
    dec_t        snap;

    // Reference decoder: immediates via signed arithmetic, legality via instruction-class rules.
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t        d;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [31:0] sgn;
        bit          legal;
        opc   = i[6:0];
        f3    = i[14:12];
        f7    = i[31:25];
        sgn   = i[31] ? 32'hFFFF_FFFF : 32'h0;
        imm_i = 32'($signed(i) >>> 20);
        imm_s = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
        imm_b = (sgn << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        imm_u = i & 32'hFFFF_F000;
        imm_j = (sgn << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        d     = '0;
        d.op  = 6'd63;
        legal = 1'b1;
        if (opc == 7'h33) begin
            if (f7 == 7'h00)                 d.op = F3_CODE[f3];
            else if (f7 == 7'h20 && f3 == 0) d.op = 6'd1;
            else if (f7 == 7'h20 && f3 == 5) d.op = 6'd7;
            else                             legal = 1'b0;
            d.shsrc = (f3 == 3'd1) || (f3 == 3'd5);
        end else if (opc == 7'h13) begin
            d.s2  = 1'b1;
            d.imm = imm_i;
            if (f3 == 1 && f7 != 0)          legal = 1'b0;
            else if (f3 == 5 && f7 == 7'h20) d.op = 6'd7;
            else if (f3 == 5 && f7 != 0)     legal = 1'b0;
            else                             d.op = F3_CODE[f3];
        end else if (opc == 7'h03 || opc == 7'h23) begin
            d.op  = 6'd0;
            d.s2  = 1'b1;
            d.imm = (opc == 7'h03) ? imm_i : imm_s;
        end else if (opc == 7'h63) begin
            d.imm = imm_b;
            if (f3 == 2 || f3 == 3) legal = 1'b0;
            else d.op = (f3 < 4) ? 6'd1 : ((f3 < 6) ? 6'd3 : 6'd4);
        end else if (opc == 7'h37) begin
            d.op = 6'd10; d.s2 = 1'b1; d.imm = imm_u;
        end else if (opc == 7'h17) begin
            d.op = 6'd0; d.s1 = 1'b1; d.s2 = 1'b1; d.imm = imm_u;
        end else if (opc == 7'h6F) begin
            d.op = 6'd0; d.s1 = 1'b1; d.s2 = 1'b1; d.imm = imm_j;
        end else if (opc == 7'h67 && f3 == 0) begin
            d.op = 6'd0; d.s2 = 1'b1; d.imm = imm_i;
        end else begin
            legal = 1'b0;
        end
        d.shamt = {1'b0, i[24:20]};
        if (!legal) begin
            d     = '0;
            d.op  = 6'd63;
            d.ill = 1'b1;
        end
        return d;
    endfunction

    function automatic dec_t dut_dec();
        dec_t d;
        d.op    = bus.ALU_INSTRUCTION;
        d.shamt = bus.SHIFT_AMOUNT;
        d.shsrc = bus.SHAMT_SRC;
        d.s1    = bus.ALU_SRC1;
        d.s2    = bus.ALU_SRC2;
        d.imm   = bus.IMMEDIATE;
        d.ill   = bus.ILLEGAL;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(bus.OUT_VALID), 64'(m_valid));
        chk("illegal_count", 64'(bus.ILLEGAL_COUNT), 64'(m_cnt));
        if (m_valid) chk("decoded", 64'(dut_dec()), 64'(m_dec));
    endtask

    // One clock of stimulus: drive, check IN_READY, clock, advance model, check outputs.
    task automatic step(input logic iv, input logic [31:0] ins, input logic fl,
                        input logic ordy, input logic rs, input bit chk_en);
        logic exp_rdy;
        bus.IN_VALID    = iv;
        bus.INSTRUCTION = ins;
        bus.FLUSH       = fl;
        bus.OUT_READY   = ordy;
        RST             = rs;
        #1;
        exp_rdy = !m_valid || ordy || fl;
        if (chk_en && !rs) chk("in_ready", 64'(bus.IN_READY), 64'(exp_rdy));
        @(posedge CLK);
        if (rs) begin
            m_valid = 1'b0;
            m_cnt   = '0;
        end else if (fl) begin
            m_valid = 1'b0;
        end else if (iv && exp_rdy) begin
            m_dec   = ref_decode(ins);
            m_valid = 1'b1;
            if (m_dec.ill && m_cnt != 16'hFFFF) m_cnt++;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
        if (chk_en) check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        dec_t rd;
        rd    = '0;
        rd.op = 6'h3F;
        chk({tag, "_valid"}, 64'(bus.OUT_VALID), 64'd0);
        chk({tag, "_count"}, 64'(bus.ILLEGAL_COUNT), 64'd0);
        chk({tag, "_outs"}, 64'(dut_dec()), 64'(rd));
        chk({tag, "_in_ready"}, 64'(bus.IN_READY), 64'd1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = r[31:25];
        endcase
        return {f7, r[24:7], OPC_LIST[$urandom_range(0, 9)]};
    endfunction

    initial begin
        m_valid = 1'b0;
        m_cnt   = '0;
        m_dec   = '0;

        // Reset and idle state.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_reset_state("reset");

        // ADD x3,x1,x2.
        step(1'b1, 32'h002081B3, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("add_valid", 64'(bus.OUT_VALID), 64'd1);
        chk("add_code", 64'(bus.ALU_INSTRUCTION), 64'd0);
        chk("add_srcs", 64'({bus.ALU_SRC1, bus.ALU_SRC2, bus.ILLEGAL}), 64'd0);

        // SRAI x5,x5,7.
        step(1'b1, 32'h4072D293, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("srai_code", 64'(bus.ALU_INSTRUCTION), 64'd7);
        chk("srai_shamt", 64'(bus.SHIFT_AMOUNT), 64'd7);
        chk("srai_sel", 64'({bus.SHAMT_SRC, bus.ALU_SRC2}), 64'b01);

        // ADDI x1,x0,-1 then LUI x1,0x12345.
        step(1'b1, 32'hFFF00093, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("addi_imm", 64'(bus.IMMEDIATE), 64'hFFFF_FFFF);
        step(1'b1, 32'h123450B7, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("lui_code", 64'(bus.ALU_INSTRUCTION), 64'd10);
        chk("lui_imm", 64'(bus.IMMEDIATE), 64'h1234_5000);

        // Stall three cycles with new work pending: slot and outputs must freeze.
        snap = dut_dec();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h40208233, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("stall_in_ready", 64'(bus.IN_READY), 64'd0);
            chk("stall_hold", 64'(dut_dec()), 64'(snap));
        end
        // Release: one transfer per cycle.
        step(1'b1, 32'h40208233, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("sub_code", 64'(bus.ALU_INSTRUCTION), 64'd1);
        step(1'b1, 32'h00C0006F, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("jal_code_src1", 64'({bus.ALU_SRC1, bus.ALU_INSTRUCTION}), 64'h40);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("drain_valid", 64'(bus.OUT_VALID), 64'd0);

        // Illegal encoding twice, then flushed once.
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ill_flag_code", 64'({bus.ILLEGAL, bus.ALU_INSTRUCTION}), 64'h7F);
        chk("ill_count", 64'(bus.ILLEGAL_COUNT), 64'd2);
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("flush_count", 64'(bus.ILLEGAL_COUNT), 64'd2);
        chk("flush_valid", 64'(bus.OUT_VALID), 64'd0);

        // FLUSH against a stalled held entry.
        step(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h002081B3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("flush_held_valid", 64'(bus.OUT_VALID), 64'd0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 99) == 0), 1'b1);
        end

        // Counter saturation at all-ones.
        for (int k = 0; k < 65540; k++) begin
            step(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_count", 64'(bus.ILLEGAL_COUNT), 64'hFFFF);
        step(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("sat_hold", 64'(bus.ILLEGAL_COUNT), 64'hFFFF);

        // Reset in the middle of a stalled stream.
        step(1'b1, 32'h4072D293, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h4072D293, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.IN_VALID = 1'b0;
        RST          = 1'b0;
        #1;
        check_reset_state("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
